// File: rtl/gpu_draw_pkg.sv
// Shared types and default widths for the streaming Bresenham line rasteriser.
package gpu_draw_pkg;

    localparam int SCREEN_X_W = 10;
    localparam int SCREEN_Y_W = 9;
    localparam int COLOR_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } line_state_t;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } color_t;

endpackage

// File: rtl/gpu_draw_line_stream_if.sv
// Pixel stream from the rasteriser to the framebuffer write arbiter.
interface gpu_draw_line_stream_if #(
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int COLOR_W = 8
);
    logic               pix_valid;
    logic               pix_ready;
    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    logic [COLOR_W-1:0] pix_r;
    logic [COLOR_W-1:0] pix_g;
    logic [COLOR_W-1:0] pix_b;
    logic               pix_last;

    modport master (
        output pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, pix_last,
        output pix_ready
    );
endinterface

// File: rtl/gpu_draw_line_stream_step.sv
// One Bresenham step: both axis adjustments are decided from the pre-step error.
module gpu_bresenham_step #(
    parameter int X_W = 10,
    parameter int Y_W = 9,
    parameter int W   = 12
) (
    input  logic signed [W-1:0] err,
    input  logic signed [W-1:0] dx,
    input  logic signed [W-1:0] dy,
    input  logic [X_W-1:0]      cur_x,
    input  logic [Y_W-1:0]      cur_y,
    input  logic                sx_neg,
    input  logic                sy_neg,
    output logic signed [W-1:0] err_nxt,
    output logic [X_W-1:0]      x_nxt,
    output logic [Y_W-1:0]      y_nxt
);
    logic signed [W:0] e2_s;
    logic signed [W:0] dx_e_s;
    logic signed [W:0] dy_e_s;
    logic              step_x_s;
    logic              step_y_s;

    assign e2_s     = {err, 1'b0};
    assign dx_e_s   = {dx[W-1], dx};
    assign dy_e_s   = {dy[W-1], dy};
    assign step_x_s = (e2_s >= dy_e_s);
    assign step_y_s = (e2_s <= dx_e_s);

    // Next error and coordinates for the current pixel.
    always_comb begin
        err_nxt = err + (step_x_s ? dy : {W{1'b0}}) + (step_y_s ? dx : {W{1'b0}});
        x_nxt   = cur_x;
        y_nxt   = cur_y;
        if (!step_x_s) begin
            x_nxt = cur_x;
        end else if (sx_neg) begin
            x_nxt = cur_x - X_W'(1);
        end else begin
            x_nxt = cur_x + X_W'(1);
        end
        if (!step_y_s) begin
            y_nxt = cur_y;
        end else if (sy_neg) begin
            y_nxt = cur_y - Y_W'(1);
        end else begin
            y_nxt = cur_y + Y_W'(1);
        end
    end
endmodule

// File: rtl/gpu_draw_line_stream.sv
// Streaming Bresenham line rasteriser: one command in, one pixel per cycle out
// with backpressure, abort, last-pixel marking and optional endpoint suppression.
module gpu_draw_line_stream #(
    parameter int X_W       = gpu_draw_pkg::SCREEN_X_W,
    parameter int Y_W       = gpu_draw_pkg::SCREEN_Y_W,
    parameter int COLOR_W   = gpu_draw_pkg::COLOR_W,
    parameter bit SKIP_LAST = 1'b0
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               abort,
    input  logic [X_W-1:0]     x1,
    input  logic [Y_W-1:0]     y1,
    input  logic [X_W-1:0]     x2,
    input  logic [Y_W-1:0]     y2,
    input  logic [COLOR_W-1:0] r_i,
    input  logic [COLOR_W-1:0] g_i,
    input  logic [COLOR_W-1:0] b_i,
    output logic               busy,
    output logic               done,
    gpu_draw_line_stream_if.master pix
);
    import gpu_draw_pkg::*;

    localparam int W = ((X_W > Y_W) ? X_W : Y_W) + 2;
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_FIN  = FIN;

    logic [1:0]          state_r;
    logic [X_W-1:0]      x_r, end_x_r;
    logic [Y_W-1:0]      y_r, end_y_r;
    logic signed [W-1:0] dx_r, dy_r, err_r;
    logic                sx_neg_r, sy_neg_r;
    logic [COLOR_W-1:0]  r_r, g_r, b_r;
    logic                valid_r, busy_r, done_r;

    logic signed [W-1:0] dx_in_s, ady_in_s, err_s;
    logic [X_W-1:0]      x_s;
    logic [Y_W-1:0]      y_s;
    logic                degen_s, at_last_s, hs_s;

    assign dx_in_s  = (x1 < x2) ? W'(x2 - x1) : W'(x1 - x2);
    assign ady_in_s = (y1 < y2) ? W'(y2 - y1) : W'(y1 - y2);
    assign degen_s  = (x1 == x2) && (y1 == y2);

    gpu_bresenham_step #(.X_W(X_W), .Y_W(Y_W), .W(W)) u_step (
        .err     (err_r),
        .dx      (dx_r),
        .dy      (dy_r),
        .cur_x   (x_r),
        .cur_y   (y_r),
        .sx_neg  (sx_neg_r),
        .sy_neg  (sy_neg_r),
        .err_nxt (err_s),
        .x_nxt   (x_s),
        .y_nxt   (y_s)
    );

    // With endpoint suppression the last emitted pixel is the one whose successor is the endpoint.
    assign at_last_s = SKIP_LAST ? ((x_s == end_x_r) && (y_s == end_y_r))
                                 : ((x_r == end_x_r) && (y_r == end_y_r));
    assign hs_s      = valid_r && pix.pix_ready;

    assign pix.pix_valid = valid_r;
    assign pix.pix_x     = x_r;
    assign pix.pix_y     = y_r;
    assign pix.pix_r     = r_r;
    assign pix.pix_g     = g_r;
    assign pix.pix_b     = b_r;
    assign pix.pix_last  = valid_r && at_last_s;
    assign busy          = busy_r;
    assign done          = done_r;

    // Command FSM, endpoint/colour latches and stepper state.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r  <= ST_IDLE;
            x_r      <= {X_W{1'b0}};
            y_r      <= {Y_W{1'b0}};
            end_x_r  <= {X_W{1'b0}};
            end_y_r  <= {Y_W{1'b0}};
            dx_r     <= {W{1'b0}};
            dy_r     <= {W{1'b0}};
            err_r    <= {W{1'b0}};
            sx_neg_r <= 1'b0;
            sy_neg_r <= 1'b0;
            r_r      <= {COLOR_W{1'b0}};
            g_r      <= {COLOR_W{1'b0}};
            b_r      <= {COLOR_W{1'b0}};
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start && !abort) begin
                        end_x_r  <= x2;
                        end_y_r  <= y2;
                        dx_r     <= dx_in_s;
                        dy_r     <= -ady_in_s;
                        err_r    <= dx_in_s - ady_in_s;
                        sx_neg_r <= !(x1 < x2);
                        sy_neg_r <= !(y1 < y2);
                        x_r      <= x1;
                        y_r      <= y1;
                        r_r      <= r_i;
                        g_r      <= g_i;
                        b_r      <= b_i;
                        busy_r   <= 1'b1;
                        if (SKIP_LAST && degen_s) begin
                            state_r <= ST_FIN;
                            valid_r <= 1'b0;
                        end else begin
                            state_r <= ST_RUN;
                            valid_r <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end else if (hs_s && at_last_s) begin
                        state_r <= ST_FIN;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else if (hs_s) begin
                        x_r   <= x_s;
                        y_r   <= y_s;
                        err_r <= err_s;
                    end
                end
                ST_FIN: begin
                    // A line that emitted no pixels reaches FIN before its done pulse.
                    if (abort || done_r) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end else begin
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gpu_draw_line_stream.sv
// Directed bench: table of lines run on a normal and an endpoint-suppressing
// instance, plus hand sequences for backpressure, abort, start-while-busy and reset.
module tb_gpu_draw_line_stream;
    import gpu_draw_pkg::*;

    localparam int XW = 10;
    localparam int YW = 9;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          n_rst, start, abort;
    logic [XW-1:0] x1, x2;
    logic [YW-1:0] y1, y2;
    logic [CW-1:0] r_i, g_i, b_i;
    logic          busy0, done0, busy1, done1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gpu_draw_line_stream_if #(.X_W(XW), .Y_W(YW), .COLOR_W(CW)) pif0 ();
    gpu_draw_line_stream_if #(.X_W(XW), .Y_W(YW), .COLOR_W(CW)) pif1 ();

    gpu_draw_line_stream #(.X_W(XW), .Y_W(YW), .COLOR_W(CW), .SKIP_LAST(1'b0)) dut0 (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2), .r_i(r_i), .g_i(g_i), .b_i(b_i),
        .busy(busy0), .done(done0), .pix(pif0)
    );

    gpu_draw_line_stream #(.X_W(XW), .Y_W(YW), .COLOR_W(CW), .SKIP_LAST(1'b1)) dut1 (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2), .r_i(r_i), .g_i(g_i), .b_i(b_i),
        .busy(busy1), .done(done1), .pix(pif1)
    );

    typedef struct {
        logic [XW-1:0] x1;
        logic [YW-1:0] y1;
        logic [XW-1:0] x2;
        logic [YW-1:0] y2;
        color_t        col;
        int            n;
        logic [XW-1:0] ex [4];
        logic [YW-1:0] ey [4];
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command for a single cycle, then scrambles the command inputs.
    task automatic start_line(input logic [XW-1:0] ax1, input logic [YW-1:0] ay1,
                              input logic [XW-1:0] ax2, input logic [YW-1:0] ay2,
                              input color_t col);
        x1 = ax1; y1 = ay1; x2 = ax2; y2 = ay2;
        r_i = col.r; g_i = col.g; b_i = col.b;
        start = 1'b1;
        tick();
        start = 1'b0;
        x1 = ~ax1; y1 = ~ay1; x2 = ~ax2; y2 = ~ay2;
        r_i = ~col.r; g_i = ~col.g; b_i = ~col.b;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   dn1;
        v = vt[i];
        start_line(v.x1, v.y1, v.x2, v.y2, v.col);
        dn1 = (v.n == 1) ? 2 : v.n;
        for (int k = 1; k <= v.n + 2; k++) begin
            chk($sformatf("v%0d k%0d valid0", i, k), 64'(pif0.pix_valid), 64'(k <= v.n));
            chk($sformatf("v%0d k%0d busy0", i, k), 64'(busy0), 64'(k <= v.n));
            chk($sformatf("v%0d k%0d done0", i, k), 64'(done0), 64'(k == v.n + 1));
            if (k <= v.n) begin
                chk($sformatf("v%0d k%0d x0", i, k), 64'(pif0.pix_x), 64'(v.ex[k-1]));
                chk($sformatf("v%0d k%0d y0", i, k), 64'(pif0.pix_y), 64'(v.ey[k-1]));
                chk($sformatf("v%0d k%0d last0", i, k), 64'(pif0.pix_last), 64'(k == v.n));
                chk($sformatf("v%0d k%0d rgb0", i, k),
                    64'({pif0.pix_r, pif0.pix_g, pif0.pix_b}), 64'(v.col));
            end
            chk($sformatf("v%0d k%0d valid1", i, k), 64'(pif1.pix_valid), 64'(k < v.n));
            chk($sformatf("v%0d k%0d done1", i, k), 64'(done1), 64'(k == dn1));
            if (k < v.n) begin
                chk($sformatf("v%0d k%0d x1", i, k), 64'(pif1.pix_x), 64'(v.ex[k-1]));
                chk($sformatf("v%0d k%0d y1", i, k), 64'(pif1.pix_y), 64'(v.ey[k-1]));
                chk($sformatf("v%0d k%0d last1", i, k), 64'(pif1.pix_last), 64'(k == v.n - 1));
            end
            tick();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " valid0"}, 64'(pif0.pix_valid), 64'(0));
        chk({tag, " busy0"}, 64'(busy0), 64'(0));
        chk({tag, " done0"}, 64'(done0), 64'(0));
        chk({tag, " last0"}, 64'(pif0.pix_last), 64'(0));
        chk({tag, " xy0"}, 64'({pif0.pix_x, pif0.pix_y}), 64'(0));
        chk({tag, " rgb0"}, 64'({pif0.pix_r, pif0.pix_g, pif0.pix_b}), 64'(0));
        chk({tag, " valid1"}, 64'(pif1.pix_valid), 64'(0));
        chk({tag, " busy1"}, 64'(busy1), 64'(0));
        chk({tag, " xy1"}, 64'({pif1.pix_x, pif1.pix_y}), 64'(0));
    endtask

    initial begin
        logic          rdy [7];
        logic [XW-1:0] bx  [7];

        vt[0] = '{x1:10'd0, y1:9'd0, x2:10'd3, y2:9'd0, col:24'h112233, n:4,
                  ex:'{10'd0, 10'd1, 10'd2, 10'd3}, ey:'{9'd0, 9'd0, 9'd0, 9'd0}};
        vt[1] = '{x1:10'd0, y1:9'd0, x2:10'd1, y2:9'd3, col:24'h445566, n:4,
                  ex:'{10'd0, 10'd0, 10'd1, 10'd1}, ey:'{9'd0, 9'd1, 9'd2, 9'd3}};
        vt[2] = '{x1:10'd5, y1:9'd5, x2:10'd2, y2:9'd2, col:24'h778899, n:4,
                  ex:'{10'd5, 10'd4, 10'd3, 10'd2}, ey:'{9'd5, 9'd4, 9'd3, 9'd2}};
        vt[3] = '{x1:10'd2, y1:9'd1, x2:10'd0, y2:9'd2, col:24'hA1B2C3, n:3,
                  ex:'{10'd2, 10'd1, 10'd0, 10'd0}, ey:'{9'd1, 9'd2, 9'd2, 9'd0}};
        vt[4] = '{x1:10'd7, y1:9'd7, x2:10'd7, y2:9'd7, col:24'h0F0F0F, n:1,
                  ex:'{10'd7, 10'd0, 10'd0, 10'd0}, ey:'{9'd7, 9'd0, 9'd0, 9'd0}};
        vt[5] = '{x1:10'd4, y1:9'd3, x2:10'd4, y2:9'd0, col:24'hFFEEDD, n:4,
                  ex:'{10'd4, 10'd4, 10'd4, 10'd4}, ey:'{9'd3, 9'd2, 9'd1, 9'd0}};
        vt[6] = '{x1:10'd1023, y1:9'd511, x2:10'd1020, y2:9'd511, col:24'h123456, n:4,
                  ex:'{10'd1023, 10'd1022, 10'd1021, 10'd1020}, ey:'{9'd511, 9'd511, 9'd511, 9'd511}};

        rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bx  = '{10'd0, 10'd1, 10'd1, 10'd1, 10'd1, 10'd2, 10'd3};

        n_rst = 1'b0; start = 1'b0; abort = 1'b0;
        x1 = '0; y1 = '0; x2 = '0; y2 = '0; r_i = '0; g_i = '0; b_i = '0;
        pif0.pix_ready = 1'b1;
        pif1.pix_ready = 1'b1;
        tick(); tick(); tick();
        chk_all_zero("reset");
        n_rst = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_vec(i);
        end

        // Backpressure on (0,0)->(3,0): ready low on cycles 2-4.
        start_line(10'd0, 9'd0, 10'd3, 9'd0, 24'h5A5A5A);
        for (int k = 1; k <= 7; k++) begin
            chk($sformatf("bp k%0d valid", k), 64'(pif0.pix_valid), 64'(1));
            chk($sformatf("bp k%0d x", k), 64'(pif0.pix_x), 64'(bx[k-1]));
            chk($sformatf("bp k%0d last", k), 64'(pif0.pix_last), 64'(k == 7));
            pif0.pix_ready = rdy[k-1];
            tick();
        end
        chk("bp done", 64'(done0), 64'(1));
        chk("bp valid off", 64'(pif0.pix_valid), 64'(0));
        pif0.pix_ready = 1'b1;
        tick(); tick();

        // Abort on the second pixel of a long line, then a normal line.
        start_line(10'd0, 9'd0, 10'd9, 9'd0, 24'h010101);
        chk("ab k1 x", 64'(pif0.pix_x), 64'(0));
        tick();
        chk("ab k2 x", 64'(pif0.pix_x), 64'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab valid0", 64'(pif0.pix_valid), 64'(0));
        chk("ab busy0", 64'(busy0), 64'(0));
        chk("ab done0", 64'(done0), 64'(0));
        chk("ab valid1", 64'(pif1.pix_valid), 64'(0));
        tick();
        chk("ab done0 later", 64'(done0), 64'(0));
        chk("ab done1 later", 64'(done1), 64'(0));
        run_vec(0);

        // Start together with abort in IDLE is dropped.
        start_line(10'd0, 9'd0, 10'd3, 9'd0, 24'h020202);
        chk("sa skip", 64'(0), 64'(0) + 64'(0) * 64'(busy0));
        n_chk--;
        tick();
        abort = 1'b1; start = 1'b1;
        x1 = 10'd0; y1 = 9'd0; x2 = 10'd5; y2 = 9'd0;
        tick(); tick(); tick(); tick(); tick();
        tick();
        abort = 1'b0; start = 1'b0;
        chk("sa busy", 64'(busy0), 64'(0));
        chk("sa valid", 64'(pif0.pix_valid), 64'(0));
        tick();
        chk("sa done", 64'(done0), 64'(0));

        // Start while busy is ignored.
        start_line(10'd0, 9'd0, 10'd3, 9'd0, 24'hAABBCC);
        chk("sb k1 x", 64'(pif0.pix_x), 64'(0));
        tick();
        chk("sb k2 x", 64'(pif0.pix_x), 64'(1));
        start = 1'b1; x1 = 10'd9; y1 = 9'd9; x2 = 10'd0; y2 = 9'd0;
        r_i = 8'h01; g_i = 8'h02; b_i = 8'h03;
        tick();
        start = 1'b0;
        chk("sb k3 xy", 64'({pif0.pix_x, pif0.pix_y}), 64'({10'd2, 9'd0}));
        chk("sb k3 rgb", 64'({pif0.pix_r, pif0.pix_g, pif0.pix_b}), 64'(24'hAABBCC));
        tick();
        chk("sb k4 x", 64'(pif0.pix_x), 64'(3));
        chk("sb k4 last", 64'(pif0.pix_last), 64'(1));
        tick();
        chk("sb k5 done", 64'(done0), 64'(1));
        tick();
        chk("sb k6 valid", 64'(pif0.pix_valid), 64'(0));
        chk("sb k6 busy", 64'(busy0), 64'(0));
        chk("sb k6 done", 64'(done0), 64'(0));
        tick();

        // Reset in the middle of a line.
        start_line(10'd0, 9'd0, 10'd9, 9'd0, 24'h777777);
        tick();
        n_rst = 1'b0;
        tick();
        chk_all_zero("midrst");
        n_rst = 1'b1;
        tick();
        chk("midrst after done0", 64'(done0), 64'(0));
        chk("midrst after valid0", 64'(pif0.pix_valid), 64'(0));
        chk("midrst after done1", 64'(done1), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
